// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: rotating-priority winner search, grant held while winner requests.
// Latency: grant 1 cycle after req sampled in IDLE; release/hand-over 1 cycle after req[gnt_idx] drops.
// Backpressure: none; a holder cannot be preempted (optional RR_ARB_TIMEOUT_EN forces release after MAX_HOLD cycles).
module rr_grant_ctrl #(
    parameter int IN       = 4,
    parameter bit ACT      = 1'b1,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic [(1<<IN)-1:0]   req,
    output logic [(1<<IN)-1:0]   gnt,
    output logic [IN-1:0]        gnt_idx,
    output logic                 gnt_valid,
    output logic                 tout
);

    localparam int N = 1 << IN;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [IN-1:0]   ptr;
    logic [IN-1:0]   search_base;
    logic [IN:0]     search_res;
    logic            win_found;
    logic [IN-1:0]   win_idx;
    logic            holder_req;
    logic            timeout_hit;
    logic            rel;
    logic [N-1:0]    onehot;

    // First set bit of r at or after base, wrapping modulo N; MSB of result flags a hit.
    function automatic logic [IN:0] rr_search(input logic [N-1:0] r, input logic [IN-1:0] base);
        logic [IN:0]   res;
        logic [IN-1:0] cand;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = base + IN'(i);
            if (r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    assign holder_req = req[gnt_idx];
    assign rel        = (state == GRANT) && (!holder_req || timeout_hit);

    // On release the search restarts just past the outgoing holder, so it ranks last.
    assign search_base = (state == GRANT) ? (gnt_idx + IN'(1)) : ptr;
    assign search_res  = rr_search(req, search_base);
    assign win_found   = search_res[IN];
    assign win_idx     = search_res[IN-1:0];

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [CW-1:0] hold_cnt;

    assign timeout_hit = (state == GRANT) && holder_req && (hold_cnt == CW'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            hold_cnt <= '0;
            tout     <= 1'b0;
        end else begin
            tout <= timeout_hit;
            if ((state != GRANT) || rel) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + CW'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign tout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        ptr <= gnt_idx + IN'(1);
                        if (win_found) begin
                            gnt_idx <= win_idx;
                        end else begin
                            gnt_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    // Decode of registered state only; req never reaches gnt combinationally.
    always_comb begin
        onehot          = '0;
        onehot[gnt_idx] = gnt_valid;
        gnt             = ACT ? onehot : ~onehot;
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: directed scenarios plus randomized requests against a queue-free cycle model.
// Two instances share req and reset: one with active-high grants, one with active-low grants.
module tb_rr_grant_ctrl;

    localparam int IN       = 4;
    localparam int N        = 1 << IN;
    localparam int MAX_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt_hi, gnt_lo;
    logic [IN-1:0]  idx_hi, idx_lo;
    logic           vld_hi, vld_lo;
    logic           tout_hi, tout_lo;

    int n_tests = 0;
    int n_fail  = 0;

    // expected state after the most recent rising edge
    int m_ptr, m_idx, m_cnt;
    bit m_valid, m_tout;

    always #5 clk = ~clk;

    rr_grant_ctrl #(.IN(IN), .ACT(1'b1), .MAX_HOLD(MAX_HOLD)) u_dut_hi (
        .clk(clk), .reset_(reset_), .req(req), .gnt(gnt_hi),
        .gnt_idx(idx_hi), .gnt_valid(vld_hi), .tout(tout_hi)
    );

    rr_grant_ctrl #(.IN(IN), .ACT(1'b0), .MAX_HOLD(MAX_HOLD)) u_dut_lo (
        .clk(clk), .reset_(reset_), .req(req), .gnt(gnt_lo),
        .gnt_idx(idx_lo), .gnt_valid(vld_lo), .tout(tout_lo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int search(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_idx = 0; m_cnt = 0; m_valid = 0; m_tout = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int  w;
        bit  expire;
        m_tout = 0;
        if (!m_valid) begin
            w = search(r, m_ptr);
            if (w >= 0) begin
                m_valid = 1; m_idx = w; m_cnt = 0;
            end
        end else begin
            expire = TO_EN && (m_cnt == MAX_HOLD - 1) && r[m_idx];
            if (!r[m_idx] || expire) begin
                m_ptr = (m_idx + 1) % N;
                w = search(r, m_ptr);
                if (w >= 0) begin
                    m_idx = w; m_cnt = 0;
                end else begin
                    m_valid = 0; m_cnt = 0;
                end
                m_tout = expire;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] e_hi, e_lo;
        e_hi = '0;
        if (m_valid) e_hi[m_idx] = 1'b1;
        e_lo = ~e_hi;
        check({tag, "_gnt_hi"}, 32'(gnt_hi), 32'(e_hi));
        check({tag, "_gnt_lo"}, 32'(gnt_lo), 32'(e_lo));
        check({tag, "_valid"}, 32'(vld_hi), 32'(m_valid));
        check({tag, "_tout"}, 32'(tout_hi), 32'(m_tout));
        if (m_valid) begin
            check({tag, "_idx_hi"}, 32'(idx_hi), 32'(m_idx));
            check({tag, "_idx_lo"}, 32'(idx_lo), 32'(m_idx));
        end
    endtask

    task automatic cyc(input logic [N-1:0] r, input string tag);
        @(negedge clk);
        req = r;
        model_step(r);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt_hi"}, 32'(gnt_hi), 32'h0000);
        check({tag, "_gnt_lo"}, 32'(gnt_lo), 32'hFFFF);
        check({tag, "_valid"}, 32'(vld_hi), 32'h0);
        check({tag, "_idx"}, 32'(idx_hi), 32'h0);
        check({tag, "_tout"}, 32'(tout_hi), 32'h0);
    endtask

    // asynchronous assertion away from any clock edge
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset_ = 1'b0;
        #1;
        check_reset_vals(tag);
        model_reset();
        req = '0;
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;
        reset_ = 1'b0;
        req    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("rst_init");
        reset_ = 1'b1;

        // single requester 5, then a search from ptr 6
        cyc(16'h0020, "single");
        check("single_idx", 32'(idx_hi), 32'd5);
        cyc(16'h0020, "single");
        cyc(16'h0020, "single");
        cyc(16'h0000, "single_rel");
        check("single_drop", 32'(vld_hi), 32'd0);
        cyc(16'h0041, "after_single");
        check("ptr6_idx", 32'(idx_hi), 32'd6);
        do_reset("rst_mid");

        // full rotation with one-cycle holds, wrap 15 -> 0
        for (int i = 0; i <= N; i++) begin
            r = 16'hFFFF;
            if (m_valid) r[m_idx] = 1'b0;
            cyc(r, "rot");
            check("rot_seq", 32'(idx_hi), 32'(i % N));
        end
        cyc(16'h0000, "rot_end");

        // ptr = 14, req 0 and 3: 0 wins, 3 does not preempt
        cyc(16'h2000, "pri_setup");
        cyc(16'h0000, "pri_setup");
        cyc(16'h0009, "pri");
        check("pri_first", 32'(idx_hi), 32'd0);
        cyc(16'h0009, "pri");
        cyc(16'h0009, "pri");
        check("pri_hold", 32'(idx_hi), 32'd0);
        cyc(16'h0008, "pri");
        check("pri_second", 32'(idx_hi), 32'd3);
        cyc(16'h0000, "pri_end");

        // requesters 2 and 5 held, then 2 alone
        do_reset("rst_to");
        for (int i = 0; i < 12; i++) cyc(16'h0024, "to_two");
        for (int i = 0; i < 10; i++) cyc(16'h0004, "to_one");
        cyc(16'h0000, "to_end");

        // randomized traffic with occasional asynchronous resets
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                6, 7:    r[$urandom_range(0, N - 1)] ^= 1'b1;
                8:       if (m_valid) r[m_idx] = 1'b0;
                9:       r = N'($urandom);
                default: ;
            endcase
            cyc(r, "rnd");
            if (i % 500 == 499) begin
                do_reset("rnd_rst");
                r = '0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin grant controller sharing one resource among 2^IN requesters. Selects a winner with a rotating priority pointer and holds the grant while the winner keeps requesting. The winner's binary index is registered and decoded into a one-hot grant vector at a configurable active level. Intended as the sequencing front end for decoder-selected datapaths, where one binary select drives many enables.

## Interface
- IN, 4, index width; requester count N = 1 << IN
- ACT, `High, active level of each gnt bit; inactive bits drive ~ACT
- MAX_HOLD, 16, maximum cycles a grant is held (used only with RR_ARB_TIMEOUT_EN); must be ≥ 2

- clk  in  1  clock; all state changes on its rising edge
- reset_  in  1  asynchronous, active-low reset
- req  in  N  request vector, active high, one bit per requester
- gnt  out  N  one-hot grant at level ACT; all bits ~ACT when no grant is held
- gnt_idx  out  IN  binary index of the current winner; valid only while gnt_valid is 1
- gnt_valid  out  1  high while a grant is held
- tout  out  1  one-cycle pulse when a grant is forcibly revoked; tied 0 when the timeout is compiled out

## Operation
- Two-state FSM: IDLE and GRANT. ptr[IN-1:0] is the highest-priority requester.
- Winner search: first set bit of req, scanning ptr, ptr+1, … modulo N (wraps from N-1 to 0).
- IDLE:
  - If req is nonzero, register winner w: gnt_idx = w, gnt_valid = 1, then go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, when req[gnt_idx] is 1: hold the grant. No other requester can preempt it.
- GRANT, when req[gnt_idx] is 0 (release):
  - Set ptr = gnt_idx + 1 (mod N).
  - In the same cycle, search again from that ptr with the current req.
  - If there is a winner, grant it next cycle (back-to-back, no bubble). Otherwise gnt_valid = 0 and go to IDLE.
- gnt is a pure decode of the registered gnt_idx, qualified by gnt_valid: gnt[gnt_idx] = ACT, all other bits ~ACT. No combinational path from req to gnt.
- Simultaneous requests: resolved only through ptr order.
- A requester that deasserts and reasserts in the same release cycle is treated as released.
- Reset (asynchronous, any time, including mid-grant) gives:
  - FSM = IDLE, ptr = 0, gnt_idx = 0, gnt_valid = 0
  - gnt = all ~ACT, tout = 0, hold counter = 0
  - The first post-reset grant follows the IDLE rules.

## Timing
- Grant latency: gnt appears on the first rising edge after req is sampled in IDLE (1 cycle).
- Release latency: gnt drops, or moves to the next winner, 1 cycle after req[gnt_idx] is sampled low. The released requester therefore sees gnt for the one cycle in which it deasserted.
- Maximum wait for a continuously requesting requester: (N-1) × hold time of the other requesters, plus N cycles.

## Configuration
- RR_ARB_TIMEOUT_EN defined:
  - A hold counter of width $clog2(MAX_HOLD) clears on every new grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 and req[gnt_idx] is still 1, the controller forces a release: ptr = gnt_idx + 1, re-search, and tout = 1 for that cycle.
  - The timed-out requester may win again only if no other requester is pending. Its counter then restarts.
- RR_ARB_TIMEOUT_EN undefined:
  - No counter; grants are held indefinitely.
  - MAX_HOLD is ignored and tout is constant 0.

## Test plan
- Reset: assert reset_ = 0 mid-grant with ACT = `High → outputs immediately show gnt = 16'h0000, gnt_valid = 0, gnt_idx = 0. With ACT = `Low → gnt = 16'hFFFF.
- Single request: req = 16'h0020 for 3 cycles, then 0 → gnt = 16'h0020 one cycle after req, held 3 cycles; gnt = 0 one cycle after req drops; next search starts at ptr = 6.
- Rotation: req = 16'hFFFF, with each winner holding 1 cycle → gnt_idx sequence 0,1,2,…,15,0 with no idle cycles between grants; the wrap from 15 to 0 is checked.
- Priority: ptr = 14, req = 16'h0009 → winner 0, then 3. req[3] arriving while 0 is held does not preempt 0.
- Timeout (RR_ARB_TIMEOUT_EN, MAX_HOLD = 4): requesters 2 and 5 held high → gnt_idx 2 for 4 cycles, tout pulses, then gnt_idx 5 for 4 cycles, then back to 2. With only requester 2 active → 2 is regranted each 4 cycles and tout pulses every 4th cycle.
- Build without the macro, same stimulus as the timeout scenario → requester 2 is held indefinitely and tout stays 0.
